univ_shift_reg: RTL
===================

# univ_shift_reg

Parametrised universal shift register. It is the successor to the single-bit D flip-flop and extends it to a WIDTH-bit word with complementary Q/Qn outputs, a synchronous reset, and per-cycle modes (hold, load, shift, rotate, arithmetic shift). It also has a multi-cycle burst-shift engine driven by a start/busy/done handshake. It serves as the general-purpose storage and serialisation element for datapaths in this design.

## Interface
- WIDTH, 8, register width in bits (≥2)
- AMT_W, $clog2(WIDTH+1), width of burst shift amount (derived localparam; not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mode  in  3  op select: 000 hold, 001 load D, 010 shift left (ser_in→LSB), 011 logical shift right (ser_in→MSB), 100 rotate left, 101 rotate right, 110 arithmetic shift right, 111 reserved (= hold)
- D  in  WIDTH  parallel load data
- ser_in  in  1  serial input bit, sampled on every shift step
- start  in  1  request burst shift of amt steps using op in mode
- amt  in  AMT_W  burst step count
- Q  out  WIDTH  register contents
- Qn  out  WIDTH  ~Q (combinational)
- ser_out_msb  out  1  Q[WIDTH-1]
- ser_out_lsb  out  1  Q[0]
- busy  out  1  burst in progress
- done  out  1  one-cycle burst-complete pulse

## Operation
- The FSM has three states: IDLE, BUSY, DONE. The state register and count register are internal.
- **IDLE:**
  - If start=1 and mode ∈ {010..110}: latch op ← mode; latch count ← min(amt, WIDTH). Go to BUSY, or to DONE if the clamped amt is 0. Q is unchanged on this edge.
  - If start=1 and mode ∈ {000, 001, 111}: start is ignored and mode executes as a single-cycle op.
  - If start=0: mode executes as a single-cycle op each edge.
- **BUSY:**
  - Each edge applies the latched op once to Q and decrements count.
  - When the decrement reaches 0, go to DONE.
  - mode, start, D and amt are ignored; ser_in is still sampled for each step.
- **DONE:** Q holds and all inputs are ignored. The next edge returns to IDLE.
- **Shift rules:**
  - Shift left: Q ← {Q[WIDTH-2:0], ser_in}.
  - Logical right: Q ← {ser_in, Q[WIDTH-1:1]}.
  - Rotates feed the ejected bit back into the vacated end.
  - Arithmetic right replicates Q[WIDTH-1].
- **amt saturation:** amt > WIDTH is saturated to WIDTH. A burst rotate of WIDTH steps returns the original value.
- **Reset:** rst=1 has priority over everything. On the edge it forces Q=0, state IDLE, count=0, busy=0 and done=0, so Qn is all ones. Reset mid-burst aborts the burst and done never pulses for it.
- **Outputs:** busy=1 exactly in BUSY; done=1 exactly in DONE. Both are decoded from registered state, so they are glitch-free.

## Timing
- Single-cycle ops: Q reflects the op after the edge at which mode is sampled (latency 1).
- Qn, ser_out_msb and ser_out_lsb are combinational from Q, with zero added latency.
- Burst with clamped amt=k≥1, start accepted at edge t:
  - busy is high from after edge t through edge t+k.
  - Shifts occur at edges t+1…t+k.
  - done is high for the single cycle after edge t+k.
  - IDLE is reached after edge t+k+1.
  - The earliest next start is sampled at edge t+k+2.
- Burst with amt=0: done is high for the cycle after edge t, busy never asserts, and Q is unchanged.
- Throughput: one single-cycle op per clock in IDLE; a burst occupies k+2 cycles.

## Test plan
- **Reset:** hold rst=1 for 2 edges with mode=001, D=8'hA5 → Q=8'h00, Qn=8'hFF, busy=0, done=0. Release rst → the next edge loads, Q=8'hA5, Qn=8'h5A.
- **Single ops (WIDTH=8):**
  - Load 8'hA5, then mode=010 with ser_in=1 → 8'h4B.
  - Load 8'h96, then mode=110 → 8'hCB.
  - Load 8'h96, then mode=101 → 8'h4B.
  - Load 8'h25, then mode=100 → 8'h4A.
  - Mode 000 or 111 holds the value.
- **Burst:** load 8'h81, then start=1, mode=100, amt=3 → busy high for exactly 3 cycles, Q=8'h0C afterwards, done pulses exactly 1 cycle, then IDLE.
- **Boundaries:**
  - amt=0 → done pulse one cycle after start; Q unchanged; busy stays 0.
  - amt=15 with mode=100 → saturates to 8 steps; busy high 8 cycles; Q returns to its starting value.
- **Ignored inputs / abort:**
  - During BUSY, toggle mode=001, D=8'hFF and start → no effect on Q or on the burst length.
  - During DONE, start is ignored.
  - Assert rst on the second BUSY cycle → Q=8'h00, busy=0, no done pulse.
- **Start with non-shift mode:** start=1, mode=001, D=8'h3C → Q=8'h3C after 1 edge; busy and done stay 0.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/arith per cycle,
// plus a start/busy/done burst engine that repeats a shift op amt times.
module univ_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             ser_in,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [AMT_W-1:0] count;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt_sat;
  logic             shift_mode;

  function automatic logic [WIDTH-1:0] step(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] q,
    input logic             si
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (m)
      3'b010:  r = {q[WIDTH-2:0], si};
      3'b011:  r = {si, q[WIDTH-1:1]};
      3'b100:  r = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b101:  r = {q[0], q[WIDTH-1:1]};
      3'b110:  r = {q[WIDTH-1], q[WIDTH-1:1]};
      default: r = q;
    endcase
    return r;
  endfunction

  assign shift_mode = (mode >= 3'b010) && (mode <= 3'b110);
  assign amt_sat    = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;

  always_ff @(posedge clk) begin
    if (rst) begin
      Q     <= '0;
      state <= IDLE;
      count <= '0;
      op    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && shift_mode) begin
            op    <= mode;
            count <= amt_sat;
            state <= (amt_sat == '0) ? DONE : BUSY;
          end else if (mode == 3'b001) begin
            Q <= D;
          end else begin
            Q <= step(mode, Q, ser_in);
          end
        end
        BUSY: begin
          // latched op only; live mode/D/start are ignored here
          Q     <= step(op, Q, ser_in);
          count <= count - AMT_W'(1);
          if (count == AMT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Qn          = ~Q;
  assign ser_out_msb = Q[WIDTH-1];
  assign ser_out_lsb = Q[0];
  assign busy        = (state == BUSY);
  assign done        = (state == DONE);

endmodule
